// File: rtl/axis_ramp_sequencer_if.sv
// ============================================================================
//  Module   : axis_ramp_sequencer_if
//  Purpose  : AXI-Stream master/slave bundle carrying ramp samples.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_ramp_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_ramp_sequencer.sv
// ============================================================================
//  Module   : axis_ramp_sequencer
//  Purpose  : Emits a linear AXI-Stream ramp (start, step, len) per request.
//             Define AXIS_RAMP_SEQ_PENDING_EN to queue one request during a ramp.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_ramp_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 18,
    parameter int OVR_WIDTH  = 16
) (
    input  wire logic                  aclk,
    input  wire logic                  aresetn,
    input  wire logic [DATA_WIDTH-1:0] cfg_start,
    input  wire logic [DATA_WIDTH-1:0] cfg_step,
    input  wire logic [LEN_WIDTH-1:0]  cfg_len,
    input  wire logic                  ramp_rq,
    output logic                       busy,
    output logic                       done,
    output logic [OVR_WIDTH-1:0]       overrun_cnt,
    axis_ramp_sequencer_if.master      m_axis
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [DATA_WIDTH-1:0] r_step;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [OVR_WIDTH-1:0]  r_ovr;

    state_t                w_state;
    logic [DATA_WIDTH-1:0] w_tdata;
    logic [DATA_WIDTH-1:0] w_step;
    logic [LEN_WIDTH-1:0]  w_len;
    logic [LEN_WIDTH-1:0]  w_cnt;
    logic [OVR_WIDTH-1:0]  w_ovr;
    logic                  w_ovr_inc;
    logic                  w_load;
    logic                  w_last;
    logic                  w_beat;

`ifdef AXIS_RAMP_SEQ_PENDING_EN
    logic                  r_pending;
    logic                  w_pending;
`endif

    assign w_last = (r_state == ST_RUN) && (r_cnt == r_len - 1'b1);
    assign w_beat = (r_state == ST_RUN) && m_axis.tready;

    always_comb begin
        w_state   = r_state;
        w_tdata   = r_tdata;
        w_step    = r_step;
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_ovr_inc = 1'b0;
        w_load    = 1'b0;
`ifdef AXIS_RAMP_SEQ_PENDING_EN
        w_pending = r_pending;
`endif
        case (r_state)
            ST_IDLE: begin
                // Zero-length requests are dropped silently, not counted.
                if (ramp_rq && (cfg_len != '0)) begin
                    w_load  = 1'b1;
                    w_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_beat) begin
                    w_tdata = r_tdata + r_step;
                    w_cnt   = r_cnt + 1'b1;
                    if (w_last) begin
                        w_state = ST_DONE;
                    end
                end
`ifdef AXIS_RAMP_SEQ_PENDING_EN
                if (ramp_rq) begin
                    if (r_pending) begin
                        w_ovr_inc = 1'b1;
                    end else begin
                        w_pending = 1'b1;
                    end
                end
`else
                if (ramp_rq) begin
                    w_ovr_inc = 1'b1;
                end
`endif
            end
            ST_DONE: begin
`ifdef AXIS_RAMP_SEQ_PENDING_EN
                // A request arriving in DONE itself is consumed by the restart.
                if (ramp_rq && r_pending) begin
                    w_ovr_inc = 1'b1;
                end
                w_state = ST_IDLE;
                if (r_pending || ramp_rq) begin
                    w_pending = 1'b0;
                    if (cfg_len != '0) begin
                        w_load  = 1'b1;
                        w_state = ST_RUN;
                    end
                end
`else
                if (ramp_rq) begin
                    w_ovr_inc = 1'b1;
                end
                w_state = ST_IDLE;
`endif
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_tdata = cfg_start;
            w_step  = cfg_step;
            w_len   = cfg_len;
            w_cnt   = '0;
        end

        w_ovr = (w_ovr_inc && (r_ovr != {OVR_WIDTH{1'b1}})) ? r_ovr + 1'b1 : r_ovr;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_tdata   <= '0;
            r_step    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_ovr     <= '0;
`ifdef AXIS_RAMP_SEQ_PENDING_EN
            r_pending <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_tdata   <= w_tdata;
            r_step    <= w_step;
            r_len     <= w_len;
            r_cnt     <= w_cnt;
            r_ovr     <= w_ovr;
`ifdef AXIS_RAMP_SEQ_PENDING_EN
            r_pending <= w_pending;
`endif
        end
    end

    // Outputs decode straight from registers so reset clears them immediately.
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = (r_state == ST_RUN);
    assign m_axis.tlast  = w_last;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign overrun_cnt   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_axis_ramp_sequencer.sv
// ============================================================================
//  Module   : tb_axis_ramp_sequencer
//  Purpose  : Self-checking bench for axis_ramp_sequencer against a ramp model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_ramp_sequencer;

    localparam int DW = 16;
    localparam int LW = 18;
    localparam int OW = 16;

    logic          aclk      = 1'b0;
    logic          aresetn   = 1'b0;
    logic [DW-1:0] cfg_start = '0;
    logic [DW-1:0] cfg_step  = '0;
    logic [LW-1:0] cfg_len   = '0;
    logic          ramp_rq   = 1'b0;
    logic          busy;
    logic          done;
    logic [OW-1:0] overrun_cnt;

    axis_ramp_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

    axis_ramp_sequencer #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .OVR_WIDTH  (OW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cfg_start   (cfg_start),
        .cfg_step    (cfg_step),
        .cfg_len     (cfg_len),
        .ramp_rq     (ramp_rq),
        .busy        (busy),
        .done        (done),
        .overrun_cnt (overrun_cnt),
        .m_axis      (m_if)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    // Observations gathered by run_ramp
    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    int            n_done;
    int            done_c;
    int            last_c;
    int            n_stall_bad;
    logic          first_valid;
    logic [DW-1:0] first_data;
    logic          busy_after;

    // Issues one request, drives tready, and records every accepted beat.
    task automatic run_ramp(input logic [DW-1:0] st, input logic [DW-1:0] sp,
                            input logic [LW-1:0] ln, input bit rnd,
                            input logic [6:0] pat, input int budget);
        bit            held = 1'b0;
        bit            fin  = 1'b0;
        bit            rdy;
        logic [DW-1:0] hd = '0;
        logic          hl = 1'b0;
        q_data.delete();
        q_last.delete();
        n_done = 0; done_c = -1; last_c = -1; n_stall_bad = 0; busy_after = 1'b1;
        cfg_start = st; cfg_step = sp; cfg_len = ln; ramp_rq = 1'b1;
        @(posedge aclk); #1;
        ramp_rq   = 1'b0;
        cfg_start = DW'($urandom);
        cfg_step  = DW'($urandom);
        cfg_len   = LW'($urandom);
        first_valid = m_if.tvalid;
        first_data  = m_if.tdata;
        for (int c = 0; c < budget && !fin; c++) begin
            rdy = rnd ? (($urandom % 4) != 0) : ((c < 7) ? pat[6-c] : 1'b1);
            m_if.tready = rdy;
            if (held && (m_if.tvalid !== 1'b1 || m_if.tdata !== hd || m_if.tlast !== hl))
                n_stall_bad++;
            held = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                done_c = c;
            end
            if (m_if.tvalid === 1'b1) begin
                if (rdy) begin
                    q_data.push_back(m_if.tdata);
                    q_last.push_back(m_if.tlast);
                    last_c = c;
                end else begin
                    held = 1'b1; hd = m_if.tdata; hl = m_if.tlast;
                end
            end
            @(posedge aclk); #1;
            if (n_done > 0) begin
                busy_after = busy;
                fin = 1'b1;
            end
        end
        m_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        ramp_rq = 1'b1; cfg_len = 18'd4; cfg_start = 16'h55AA;
        #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b exp=0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL reset_tdata got=%h exp=0", m_if.tdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_vec++; if (overrun_cnt !== '0) begin n_err++; $display("FAIL reset_ovr got=%0d exp=0", overrun_cnt); end
        @(posedge aclk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_held_busy got=%b exp=0", busy); end
        ramp_rq = 1'b0;
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got=%b exp=0", m_if.tvalid); end
    endtask

    task automatic test_zero_len();
        int any_valid = 0;
        int any_done  = 0;
        int any_busy  = 0;
        cfg_start = 16'd9; cfg_step = 16'd1; cfg_len = '0; ramp_rq = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge aclk); #1;
            if (c == 1) ramp_rq = 1'b0;
            if (m_if.tvalid === 1'b1) any_valid++;
            if (done === 1'b1) any_done++;
            if (busy === 1'b1) any_busy++;
        end
        n_vec++; if (any_valid != 0) begin n_err++; $display("FAIL zero_len_tvalid got=%0d exp=0", any_valid); end
        n_vec++; if (any_done != 0) begin n_err++; $display("FAIL zero_len_done got=%0d exp=0", any_done); end
        n_vec++; if (any_busy != 0) begin n_err++; $display("FAIL zero_len_busy got=%0d exp=0", any_busy); end
        n_vec++; if (overrun_cnt !== '0) begin n_err++; $display("FAIL zero_len_ovr got=%0d exp=0", overrun_cnt); end
    endtask

    // Directed ramps (basic, wrap, stall pattern) followed by randomized ones.
    task automatic test_ramp_scenarios();
        logic [DW-1:0] st, sp, e_data;
        logic [LW-1:0] ln;
        logic [OW-1:0] ovr0;
        logic [6:0]    pat;
        bit            rnd;
        int            n;
        for (int s = 0; s < 12; s++) begin
            case (s)
                0:       begin st = 16'd100;  sp = 16'd5;    ln = 18'd4; rnd = 1'b0; pat = 7'h7F; end
                1:       begin st = 16'hFFFE; sp = 16'd1;    ln = 18'd4; rnd = 1'b0; pat = 7'h7F; end
                2:       begin st = 16'd7;    sp = 16'hFFFD; ln = 18'd3; rnd = 1'b0; pat = 7'b1001011; end
                3:       begin st = 16'h1234; sp = 16'd0;    ln = 18'd1; rnd = 1'b0; pat = 7'b0001111; end
                default: begin
                    st = DW'($urandom); sp = DW'($urandom);
                    ln = LW'($urandom_range(1, 20)); rnd = 1'b1; pat = 7'h7F;
                end
            endcase
            ovr0 = overrun_cnt;
            run_ramp(st, sp, ln, rnd, pat, 8 * int'(ln) + 40);
            n_vec++; if (first_valid !== 1'b1) begin n_err++; $display("FAIL s%0d first_tvalid got=%b exp=1", s, first_valid); end
            n_vec++; if (first_data !== st) begin n_err++; $display("FAIL s%0d first_tdata got=%h exp=%h", s, first_data, st); end
            n_vec++; if (q_data.size() != int'(ln)) begin n_err++; $display("FAIL s%0d beat_count got=%0d exp=%0d", s, q_data.size(), ln); end
            n = (q_data.size() < int'(ln)) ? q_data.size() : int'(ln);
            for (int i = 0; i < n; i++) begin
                e_data = DW'(int'(st) + int'(sp) * i);
                n_vec++; if (q_data[i] !== e_data) begin n_err++; $display("FAIL s%0d beat%0d_tdata got=%h exp=%h", s, i, q_data[i], e_data); end
                n_vec++; if (q_last[i] !== (i == int'(ln) - 1)) begin n_err++; $display("FAIL s%0d beat%0d_tlast got=%b exp=%b", s, i, q_last[i], (i == int'(ln) - 1)); end
            end
            n_vec++; if (n_done != 1) begin n_err++; $display("FAIL s%0d done_pulses got=%0d exp=1", s, n_done); end
            n_vec++; if (done_c != last_c + 1) begin n_err++; $display("FAIL s%0d done_cycle got=%0d exp=%0d", s, done_c, last_c + 1); end
            n_vec++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL s%0d busy_after got=%b exp=0", s, busy_after); end
            n_vec++; if (n_stall_bad != 0) begin n_err++; $display("FAIL s%0d stall_stability got=%0d exp=0", s, n_stall_bad); end
            n_vec++; if (overrun_cnt !== ovr0) begin n_err++; $display("FAIL s%0d overrun got=%0d exp=%0d", s, overrun_cnt, ovr0); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got[$];
        logic [DW-1:0] e_data;
        int            nd = 0;
        int            e_beats, e_done, e_ovr;
`ifdef AXIS_RAMP_SEQ_PENDING_EN
        e_beats = 4; e_done = 2; e_ovr = 1;
`else
        e_beats = 2; e_done = 1; e_ovr = 2;
`endif
        @(negedge aclk); aresetn = 1'b0;
        @(negedge aclk); aresetn = 1'b1;
        cfg_start = 16'd10; cfg_step = 16'd1; cfg_len = 18'd2;
        m_if.tready = 1'b1; ramp_rq = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge aclk); #1;
            if (c == 2) ramp_rq = 1'b0;
            if (m_if.tvalid === 1'b1) got.push_back(m_if.tdata);
            if (done === 1'b1) nd++;
        end
        n_vec++; if (got.size() != e_beats) begin n_err++; $display("FAIL b2b_beats got=%0d exp=%0d", got.size(), e_beats); end
        for (int i = 0; i < got.size() && i < e_beats; i++) begin
            e_data = DW'(10 + (i % 2));
            n_vec++; if (got[i] !== e_data) begin n_err++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got[i], e_data); end
        end
        n_vec++; if (nd != e_done) begin n_err++; $display("FAIL b2b_done got=%0d exp=%0d", nd, e_done); end
        n_vec++; if (overrun_cnt !== OW'(e_ovr)) begin n_err++; $display("FAIL b2b_overrun got=%0d exp=%0d", overrun_cnt, e_ovr); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_reset_midramp();
        logic [DW-1:0] e_data;
        int            nd = 0;
        int            waited = 0;
        cfg_start = 16'h1234; cfg_step = 16'd3; cfg_len = 18'd1000;
        m_if.tready = 1'b1; ramp_rq = 1'b1;
        @(posedge aclk); #1;
        ramp_rq = 1'b0;
        for (int c = 0; c < 10; c++) @(posedge aclk);
        #1;
        e_data = DW'(16'h1234 + 10 * 3);
        n_vec++; if (m_if.tdata !== e_data) begin n_err++; $display("FAIL mid_tdata got=%h exp=%h", m_if.tdata, e_data); end
        #2; aresetn = 1'b0; #1;
        n_vec++; if (m_if.tvalid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tvalid got=%b exp=0", m_if.tvalid); end
        n_vec++; if (m_if.tlast !== 1'b0) begin n_err++; $display("FAIL mid_rst_tlast got=%b exp=0", m_if.tlast); end
        n_vec++; if (m_if.tdata !== '0) begin n_err++; $display("FAIL mid_rst_tdata got=%h exp=0", m_if.tdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        n_vec++; if (overrun_cnt !== '0) begin n_err++; $display("FAIL mid_rst_ovr got=%0d exp=0", overrun_cnt); end
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk); #1;
            if (done === 1'b1) nd++;
        end
        @(negedge aclk); aresetn = 1'b1;
        @(posedge aclk); #1;
        if (done === 1'b1) nd++;
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL mid_rst_done got=%0d exp=0", nd); end
        cfg_start = 16'h0777; cfg_step = 16'd2; cfg_len = 18'd5; ramp_rq = 1'b1;
        @(posedge aclk); #1;
        ramp_rq = 1'b0;
        n_vec++; if (m_if.tvalid !== 1'b1) begin n_err++; $display("FAIL restart_tvalid got=%b exp=1", m_if.tvalid); end
        n_vec++; if (m_if.tdata !== 16'h0777) begin n_err++; $display("FAIL restart_tdata got=%h exp=0777", m_if.tdata); end
        while (busy === 1'b1 && waited < 20) begin
            @(posedge aclk); #1;
            waited++;
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL restart_complete got=%b exp=0", busy); end
    endtask

    initial begin
        m_if.tready = 1'b1;
        test_reset();
        test_zero_len();
        test_ramp_scenarios();
        test_back_to_back();
        test_reset_midramp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
